// File: rtl/decode_stage_hz.sv
// ID stage: register file with write-back bypass, instruction decode,
// load-use hazard detection, ID/EX pipeline register and a saturating
// stall counter.
module decode_stage_hz #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 flush,
    input  logic                 instr_valid,
    input  logic [31:0]          instr_in,
    input  logic                 wb_we,
    input  logic [RA_W-1:0]      wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic                 ex_mem_read,
    input  logic [RA_W-1:0]      ex_rt,
    output logic [XLEN-1:0]      data1,
    output logic [XLEN-1:0]      data2,
    output logic [XLEN-1:0]      ext_sig,
    output logic [RA_W-1:0]      rs,
    output logic [RA_W-1:0]      rt,
    output logic [RA_W-1:0]      rd,
    output logic [11:0]          ctrl_word,
    output logic                 out_valid,
    output logic                 illegal,
    output logic                 stall,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [NREG*XLEN-1:0] registros
);

    typedef struct packed {
        logic       branch;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src;
        logic [5:0] alu_op;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] ALU_ADD  = 6'b100000;
    localparam logic [5:0] ALU_SUB  = 6'b100010;

    // Instruction fields, register specifiers truncated to RA_W
    logic [5:0]      opcode;
    logic [RA_W-1:0] rs_f, rt_f, rd_f;
    logic [XLEN-1:0] imm_ext;

    assign opcode  = instr_in[31:26];
    assign rs_f    = instr_in[21 +: RA_W];
    assign rt_f    = instr_in[16 +: RA_W];
    assign rd_f    = instr_in[11 +: RA_W];
    assign imm_ext = {{(XLEN-16){instr_in[15]}}, instr_in[15:0]};

    // Register file; r0 is only ever cleared, never written
    logic [XLEN-1:0] rf_q [NREG];

    // Write-back port, independent of ena/stall/flush
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
        end else if (wb_we && (wb_addr != '0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_dump
        assign registros[g*XLEN +: XLEN] = rf_q[g];
    end

    // Operand read with same-cycle write-back bypass
    logic [XLEN-1:0] rd1, rd2;
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs_f != '0) rd1 = (wb_we && wb_addr == rs_f) ? wb_data : rf_q[rs_f];
        if (rt_f != '0) rd2 = (wb_we && wb_addr == rt_f) ? wb_data : rf_q[rt_f];
    end

    // Opcode decode into the control word
    ctrl_t ctrl_dec;
    logic  ill_dec;
    always_comb begin
        ctrl_dec = '0;
        ill_dec  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_dec.reg_dst   = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = instr_in[5:0];
            end
            OP_LW: begin
                ctrl_dec.alu_src    = 1'b1;
                ctrl_dec.mem_to_reg = 1'b1;
                ctrl_dec.reg_write  = 1'b1;
                ctrl_dec.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.mem_write = 1'b1;
                ctrl_dec.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl_dec.branch = 1'b1;
                ctrl_dec.alu_op = ALU_SUB;
            end
            OP_ADDI: begin
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = ALU_ADD;
            end
            default: ill_dec = 1'b1;
        endcase
    end

    // Load-use hazard; a load into r0 never stalls, flush suppresses it
    assign stall = instr_valid & ex_mem_read & (ex_rt != '0) &
                   ((ex_rt == rs_f) | (ex_rt == rt_f)) & ~flush;

    // ID/EX register
    logic [XLEN-1:0] data1_q, data2_q, ext_q;
    logic [RA_W-1:0] rs_q, rt_q, rd_q;
    ctrl_t           ctrl_q;
    logic            vld_q, ill_q;
    logic [XLEN-1:0] data1_d, data2_d, ext_d;
    logic [RA_W-1:0] rs_d, rt_d, rd_d;
    ctrl_t           ctrl_d;
    logic            vld_d, ill_d;

    // Next-state: flush > hold > stall/invalid bubble > issue
    always_comb begin
        data1_d = data1_q;
        data2_d = data2_q;
        ext_d   = ext_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        ctrl_d  = ctrl_q;
        vld_d   = vld_q;
        ill_d   = ill_q;
        if (flush || ena) begin
            data1_d = rd1;
            data2_d = rd2;
            ext_d   = imm_ext;
            rs_d    = rs_f;
            rt_d    = rt_f;
            rd_d    = rd_f;
            if (flush || stall || !instr_valid) begin
                ctrl_d = '0;
                vld_d  = 1'b0;
                ill_d  = 1'b0;
            end else begin
                ctrl_d = ctrl_dec;
                vld_d  = 1'b1;
                ill_d  = ill_dec;
            end
        end
    end

    // Pipeline register state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data1_q <= '0;
            data2_q <= '0;
            ext_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            ctrl_q  <= '0;
            vld_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            data1_q <= data1_d;
            data2_q <= data2_d;
            ext_q   <= ext_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            ctrl_q  <= ctrl_d;
            vld_q   <= vld_d;
            ill_q   <= ill_d;
        end
    end

    // Saturating count of stall cycles that actually held the pipe
    logic [CNT_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                  cnt_q <= '0;
        else if (stall && ena && (cnt_q != '1))    cnt_q <= cnt_q + 1'b1;
    end

    assign data1     = data1_q;
    assign data2     = data2_q;
    assign ext_sig   = ext_q;
    assign rs        = rs_q;
    assign rt        = rt_q;
    assign rd        = rd_q;
    assign ctrl_word = ctrl_q;
    assign out_valid = vld_q;
    assign illegal   = ill_q;
    assign stall_cnt = cnt_q;

endmodule

// File: doc/decode_stage_hz.md
# decode_stage_hz

Parametrised ID stage with an integrated ID/EX pipeline register, a register file with write-back bypass, load-use hazard detection, and flush/bubble control. It sits between the IF/ID register and the execute stage. Each cycle it decodes one instruction into operands, a sign-extended immediate, register specifiers and a control word. On a load-use hazard it stalls fetch for one cycle and issues a bubble to EX. It also keeps a saturating stall counter for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath and register width.
- NREG, 32, number of architectural registers; must be a power of two, at most 32. Register 0 reads as zero.
- RA_W, 5, register address width; must equal log2(NREG).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-low; clears all state.
- ena  in  1  pipeline advance enable; 0 holds all output registers.
- flush  in  1  squash the instruction being decoded; a bubble is loaded.
- instr_valid  in  1  instr_in holds a real instruction.
- instr_in  in  32  instruction from IF/ID.
- wb_we  in  1  write-back enable.
- wb_addr  in  RA_W  write-back register.
- wb_data  in  XLEN  write-back data.
- ex_mem_read  in  1  the instruction currently in EX is a load.
- ex_rt  in  RA_W  destination register of that load.
- data1, data2  out  XLEN  registered rs and rt operands.
- ext_sig  out  XLEN  registered sign-extended instr[15:0].
- rs, rt, rd  out  RA_W  registered instr[25:21], instr[20:16] and instr[15:11], truncated to RA_W.
- ctrl_word  out  12  registered {branch, mem_write, mem_to_reg, reg_dst, reg_write, alu_src, alu_op[5:0]}.
- out_valid  out  1  registered; the EX slot holds a real instruction.
- illegal  out  1  registered; the valid instruction has an unknown opcode.
- stall  out  1  combinational; hold the PC and IF/ID this cycle.
- stall_cnt  out  CNT_W  saturating count of stall cycles.
- registros  out  NREG*XLEN  flat register-file dump; register i occupies bits [i*XLEN +: XLEN].

## Operation
- Register file:
  - Written on the rising edge when wb_we=1 and wb_addr!=0.
  - Writes occur regardless of ena, stall and flush.
  - Register 0 is never written.
- Read bypass: if wb_we=1, wb_addr==rs and rs!=0, then data1 samples wb_data. The same rule applies to data2 with rt.
- Decode, by opcode (instr[31:26]):
  - 000000, R-type: reg_dst=1, reg_write=1, alu_op=funct (instr[5:0]).
  - 100011, lw: alu_src=1, mem_to_reg=1, reg_write=1, alu_op=100000.
  - 101011, sw: alu_src=1, mem_write=1, alu_op=100000.
  - 000100, beq: branch=1, alu_op=100010.
  - 001000, addi: alu_src=1, reg_write=1, alu_op=100000.
  - Any other opcode: ctrl_word=0 and illegal=1.
- Hazard: stall = instr_valid & ex_mem_read & (ex_rt!=0) & (ex_rt==rs_field | ex_rt==rt_field) & ~flush. rs_field and rt_field are the rs and rt fields of instr_in.
- Output register update priority, highest first:
  - reset;
  - flush: bubble;
  - ena=0: hold;
  - stall: bubble;
  - instr_valid=0: bubble;
  - otherwise: load the decoded instruction.
- A bubble sets ctrl_word=0, out_valid=0 and illegal=0. data1, data2, ext_sig, rs, rt and rd still load from instr_in.
- stall_cnt increments on each rising edge where stall=1 and ena=1. It saturates at all-ones and is cleared only by reset.

## Timing
- Reset:
  - Applies immediately while rst=0, including mid-operation.
  - All registered outputs go to 0, all registers in the file go to 0, and stall_cnt goes to 0.
  - stall follows its inputs combinationally even during reset.
- Latency: an instruction presented before rising edge k appears on the outputs after edge k, i.e. one cycle.
- A write-back and a read of the same register in the same cycle yield the new value (bypass). The file itself updates at the same edge.
- Load-use: stall is high for exactly one cycle per hazard. On the next cycle the load has left EX, the hazard clears, and the held instruction issues.
- A load writing r0 never stalls.
- Simultaneous flush and stall: flush wins, stall=0 and a bubble is loaded.
- Simultaneous ena=0 and stall: the outputs hold. stall is still driven, and stall_cnt does not increment.

## Test plan
- Reset: rst=0 mid-stream → all outputs and registros are 0 asynchronously. After release, stall_cnt=0.
- Write-back bypass: wb_we=1, wb_addr=3, wb_data=0xDEADBEEF, and instr_in has rs=3 → data1=0xDEADBEEF after one edge, and registros[3*32 +: 32]=0xDEADBEEF.
- Load-use: ex_mem_read=1 and ex_rt=5 while decoding add r7,r5,r2 (0x00A23820) →
  - stall=1 for one cycle, the first output is a bubble (out_valid=0), and stall_cnt=1;
  - the next cycle gives out_valid=1 with ctrl_word {0,0,0,1,1,0,100000}.
- Flush during stall: the same hazard with flush=1 → stall=0, out_valid=0 and stall_cnt unchanged.
- Decode sweep:
  - lw with immediate 0xFFFC → ext_sig=0xFFFFFFFC, ctrl_word=0b001011100000;
  - opcode 111111 → ctrl_word=0 and illegal=1;
  - a write to r0 → r0 still reads 0.
- Saturation: with CNT_W=2, hold the hazard for 5 stalling cycles → stall_cnt reaches 3 and stays there.
